// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and constants for the memory stage.
//   - FSM state encoding for the data-memory handshake (IDLE/ISSUE/WAIT)
//   - default access timeout
//   - EX/MEM and MEM/WB register layouts (16-bit data, 3-bit register index)
//   - decode helper that flags memory ops the stage refuses to issue
package mem_stage_pkg;

    localparam int DATA_W          = 16;
    localparam int REG_W           = 3;
    localparam int TIMEOUT_CYC_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] alu_out;
        logic [DATA_W-1:0] wdata;
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
        logic [REG_W-1:0]  wreg;
        logic              halt;
        logic              err;
    } ex_mem_t;

    typedef struct packed {
        logic [DATA_W-1:0] alu_out;
        logic [DATA_W-1:0] rdata;
        logic              mem_to_reg;
        logic              reg_write;
        logic [REG_W-1:0]  wreg;
        logic              halt;
        logic              err;
    } mem_wb_t;

    // A memory op is refused when it is both a load and a store, or when its
    // word address is odd.
    function automatic logic is_illegal(input logic rd, input logic wr, input logic addr0);
        return (rd & wr) | ((rd | wr) & addr0);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: request/wait bus between the memory stage and the data memory.
//   master (memory stage): drives mem_addr, mem_data_out, mem_rd, mem_wr;
//                          receives mem_stall, mem_done, mem_data_in, mem_err.
//   slave  (data memory) : the mirror image.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_rd;
    logic              mem_wr;
    logic              mem_stall;
    logic              mem_done;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_err;

    modport master (
        output mem_addr, mem_data_out, mem_rd, mem_wr,
        input  mem_stall, mem_done, mem_data_in, mem_err
    );

    modport slave (
        input  mem_addr, mem_data_out, mem_rd, mem_wr,
        output mem_stall, mem_done, mem_data_in, mem_err
    );

endinterface

// File: rtl/mem_access_fsm.sv
// mem_access_fsm: sequences one data-memory access for the memory stage.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : a legal memory op enters the stage on this edge
//   op_read, op_write : kind of the op currently held in the stage
//   mem_stall/done    : memory handshake inputs
//   mem_rd, mem_wr    : request strobes, only ever high in ISSUE
//   complete          : the held op finishes this cycle (done or timeout)
//   timeout           : completion is due to the timeout, not to mem_done
module mem_access_fsm
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic op_read,
    input  logic op_write,
    input  logic mem_stall,
    input  logic mem_done,
    output logic mem_rd,
    output logic mem_wr,
    output logic complete,
    output logic timeout
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_ISSUE = ST_ISSUE;
    localparam logic [1:0] S_WAIT  = ST_WAIT;
    localparam int         CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             active;
    logic             hit;
    logic             expired;

    assign active = (state == S_ISSUE) || (state == S_WAIT);

    // mem_done counts in ISSUE only when the request was not refused.
    assign hit      = ((state == S_ISSUE) && !mem_stall && mem_done) ||
                      ((state == S_WAIT) && mem_done);
    assign expired  = active && (cnt == CNT_W'(TIMEOUT_CYC - 1));
    // A real completion in the last allowed cycle beats the timeout.
    assign timeout  = expired && !hit;
    assign complete = hit || timeout;

    assign mem_rd = (state == S_ISSUE) && op_read;
    assign mem_wr = (state == S_ISSUE) && op_write;

    always_comb begin
        state_nxt = state;
        if (complete)
            state_nxt = S_IDLE;
        else if ((state == S_ISSUE) && !mem_stall)
            state_nxt = S_WAIT;
        // A new op captured on the completion edge goes straight back to ISSUE.
        if (start)
            state_nxt = S_ISSUE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (start)
                cnt <= '0;
            else if (active)
                cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the 16-bit 5-stage pipeline.
//   clk, rst_n     : clock, asynchronous active-low reset
//   ex_*           : instruction presented by execute (captured when mem_ready)
//   mem_ready      : stage accepts from execute this cycle (combinational)
//   mbus           : request/wait bus to the data memory (master side)
//   wb_*           : MEM/WB register; wb_valid pulses once per instruction
// Holds the EX/MEM register, back-pressures execute while a memory access is
// outstanding, and loads MEM/WB on the cycle the held instruction completes.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu_out,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_reg_write,
    input  logic [REG_W-1:0]  ex_wreg,
    input  logic              ex_halt,
    input  logic              ex_err,
    output logic              mem_ready,
    mem_stage_if.master       mbus,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_alu_out,
    output logic [DATA_W-1:0] wb_rdata,
    output logic              wb_mem_to_reg,
    output logic              wb_reg_write,
    output logic [REG_W-1:0]  wb_wreg,
    output logic              wb_halt,
    output logic              wb_err
);

    ex_mem_t stg_p1;
    logic    vld_p1;
    mem_wb_t wb_p2;
    logic    vld_p2;

    logic illegal_p1;
    logic memop_p1;
    logic ex_memop;
    logic start;
    logic complete;
    logic timeout;
    logic hit;
    logic retire;

    assign illegal_p1 = is_illegal(stg_p1.mem_read, stg_p1.mem_write, stg_p1.alu_out[0]);
    assign memop_p1   = vld_p1 & (stg_p1.mem_read | stg_p1.mem_write) & ~illegal_p1;

    // Everything except an in-flight legal memory op finishes in one cycle.
    assign mem_ready = ~memop_p1 | complete;
    assign retire    = vld_p1 & mem_ready;
    assign hit       = complete & ~timeout;

    assign ex_memop = (ex_mem_read | ex_mem_write) &
                      ~is_illegal(ex_mem_read, ex_mem_write, ex_alu_out[0]);
    assign start    = mem_ready & ex_valid & ex_memop;

    assign mbus.mem_addr     = stg_p1.alu_out;
    assign mbus.mem_data_out = stg_p1.wdata;

    mem_access_fsm #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_read   (stg_p1.mem_read),
        .op_write  (stg_p1.mem_write),
        .mem_stall (mbus.mem_stall),
        .mem_done  (mbus.mem_done),
        .mem_rd    (mbus.mem_rd),
        .mem_wr    (mbus.mem_wr),
        .complete  (complete),
        .timeout   (timeout)
    );

    // ---- EX/MEM boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            stg_p1 <= '0;
        end else if (mem_ready) begin
            vld_p1 <= ex_valid;
            if (ex_valid)
                stg_p1 <= '{alu_out:   ex_alu_out,
                            wdata:     ex_wdata,
                            mem_read:  ex_mem_read,
                            mem_write: ex_mem_write,
                            reg_write: ex_reg_write,
                            wreg:      ex_wreg,
                            halt:      ex_halt,
                            err:       ex_err};
        end
    end

    // ---- MEM/WB boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            wb_p2  <= '0;
        end else begin
            vld_p2 <= retire;
            if (retire) begin
                wb_p2.alu_out    <= stg_p1.alu_out;
                wb_p2.rdata      <= (stg_p1.mem_read & hit) ? mbus.mem_data_in : '0;
                wb_p2.mem_to_reg <= stg_p1.mem_read;
                wb_p2.reg_write  <= stg_p1.reg_write;
                wb_p2.wreg       <= stg_p1.wreg;
                wb_p2.halt       <= stg_p1.halt;
                wb_p2.err        <= stg_p1.err | illegal_p1 | timeout | (hit & mbus.mem_err);
            end
        end
    end

    assign wb_valid      = vld_p2;
    assign wb_alu_out    = wb_p2.alu_out;
    assign wb_rdata      = wb_p2.rdata;
    assign wb_mem_to_reg = wb_p2.mem_to_reg;
    assign wb_reg_write  = wb_p2.reg_write;
    assign wb_wreg       = wb_p2.wreg;
    assign wb_halt       = wb_p2.halt;
    assign wb_err        = wb_p2.err;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage with TIMEOUT_CYC = 8.
// A reactive memory responder picks, per access, a number of refused cycles
// and a latency after acceptance; the reference model predicts from those the
// completion cycle, mem_ready, the request strobes and the MEM/WB contents.
module tb_mem_stage;

    localparam int TMO = 8;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [15:0] ex_alu_out;
    logic [15:0] ex_wdata;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_reg_write;
    logic [2:0]  ex_wreg;
    logic        ex_halt;
    logic        ex_err;
    logic        mem_ready;
    logic        wb_valid;
    logic [15:0] wb_alu_out;
    logic [15:0] wb_rdata;
    logic        wb_mem_to_reg;
    logic        wb_reg_write;
    logic [2:0]  wb_wreg;
    logic        wb_halt;
    logic        wb_err;

    mem_stage_if mif();

    mem_stage #(.TIMEOUT_CYC(TMO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_alu_out    (ex_alu_out),
        .ex_wdata      (ex_wdata),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_reg_write  (ex_reg_write),
        .ex_wreg       (ex_wreg),
        .ex_halt       (ex_halt),
        .ex_err        (ex_err),
        .mem_ready     (mem_ready),
        .mbus          (mif),
        .wb_valid      (wb_valid),
        .wb_alu_out    (wb_alu_out),
        .wb_rdata      (wb_rdata),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_reg_write  (wb_reg_write),
        .wb_wreg       (wb_wreg),
        .wb_halt       (wb_halt),
        .wb_err        (wb_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

    typedef struct packed {
        logic [15:0] alu;
        logic [15:0] wdata;
        logic        rd;
        logic        wr;
        logic        rw;
        logic [2:0]  wreg;
        logic        halt;
        logic        err;
        logic        f_en;     // fixed memory behaviour for directed cases
        int          f_s;
        int          f_l;
        logic [15:0] f_data;
    } instr_t;

    instr_t      q[$];          // accepted, not yet retired (head = in stage)
    int          vectors     = 0;
    int          miscompares = 0;

    bit          plan_valid = 0;
    int          k, ps, pl;
    logic [15:0] pdata;
    logic        perr;

    bit          exp_valid = 0;
    logic [15:0] exp_alu, exp_rdata;
    logic        exp_m2r, exp_rw, exp_halt, exp_err;
    logic [2:0]  exp_wreg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit illegal_op(input instr_t t);
        return (t.rd && t.wr) || ((t.rd || t.wr) && t.alu[0]);
    endfunction

    function automatic bit mem_op(input instr_t t);
        return (t.rd || t.wr) && !illegal_op(t);
    endfunction

    function automatic instr_t mk(input logic [15:0] alu, input logic [15:0] wd, input bit rd,
                                  input bit wr, input bit rw, input logic [2:0] wreg);
        instr_t t;
        t       = '0;
        t.alu   = alu;
        t.wdata = wd;
        t.rd    = rd;
        t.wr    = wr;
        t.rw    = rw;
        t.wreg  = wreg;
        return t;
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        int     sel;
        t      = '0;
        sel    = $urandom_range(0, 15);
        t.alu   = 16'($urandom);
        t.wdata = 16'($urandom);
        t.wreg  = 3'($urandom);
        t.err   = ($urandom_range(0, 15) == 0);
        if (sel < 6) begin
            t.rw   = 1'($urandom);
            t.halt = ($urandom_range(0, 15) == 0);
        end else if (sel < 10) begin
            t.rd = 1'b1; t.rw = 1'b1; t.alu[0] = 1'b0;
        end else if (sel < 13) begin
            t.wr = 1'b1; t.alu[0] = 1'b0;
        end else if (sel == 13) begin
            t.rd = 1'($urandom); t.wr = ~t.rd; t.rw = t.rd; t.alu[0] = 1'b1;
        end else if (sel == 14) begin
            t.rd = 1'b1; t.wr = 1'b1;
        end else begin
            t.rw = 1'b1;
        end
        return t;
    endfunction

    // One clock cycle: check MEM/WB, play the memory, drive execute.
    task automatic step(input bit v, input instr_t ins, output bit acc);
        bit comp;
        bit tmo;
        bit memop;
        bit ill;
        @(negedge clk);
        chk("wb_valid", 32'(wb_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("wb_alu_out", 32'(wb_alu_out), 32'(exp_alu));
            chk("wb_rdata", 32'(wb_rdata), 32'(exp_rdata));
            chk("wb_mem_to_reg", 32'(wb_mem_to_reg), 32'(exp_m2r));
            chk("wb_reg_write", 32'(wb_reg_write), 32'(exp_rw));
            chk("wb_wreg", 32'(wb_wreg), 32'(exp_wreg));
            chk("wb_halt", 32'(wb_halt), 32'(exp_halt));
            chk("wb_err", 32'(wb_err), 32'(exp_err));
            void'(q.pop_front());
        end
        comp = 1'b0;
        tmo  = 1'b0;
        mif.mem_stall   = 1'($urandom);
        mif.mem_done    = 1'($urandom);
        mif.mem_data_in = 16'($urandom);
        mif.mem_err     = 1'($urandom);
        if (q.size() > 0) begin
            memop = mem_op(q[0]);
            ill   = illegal_op(q[0]);
            if (memop) begin
                if (!plan_valid) begin
                    if (q[0].f_en) begin
                        ps = q[0].f_s; pl = q[0].f_l; pdata = q[0].f_data; perr = 1'b0;
                    end else begin
                        ps    = $urandom_range(0, 3);
                        case ($urandom_range(0, 9))
                            0, 1, 2, 3: pl = 0;
                            4, 5, 6, 7: pl = $urandom_range(1, 3);
                            default:    pl = $urandom_range(4, 10);
                        endcase
                        pdata = 16'($urandom);
                        perr  = ($urandom_range(0, 7) == 0);
                    end
                    k          = 0;
                    plan_valid = 1'b1;
                end
                chk("mem_rd", 32'(mif.mem_rd), 32'((k <= ps) && q[0].rd));
                chk("mem_wr", 32'(mif.mem_wr), 32'((k <= ps) && q[0].wr));
                chk("mem_addr", 32'(mif.mem_addr), 32'(q[0].alu));
                if (q[0].wr)
                    chk("mem_data_out", 32'(mif.mem_data_out), 32'(q[0].wdata));
                if (k <= ps)
                    mif.mem_stall = (k < ps);
                mif.mem_done = (k == ps + pl);
                if (k == ps + pl) begin
                    mif.mem_data_in = pdata;
                    mif.mem_err     = perr;
                end
                comp = (k == ps + pl) || (k == TMO - 1);
                tmo  = comp && (k != ps + pl);
                k++;
                if (comp)
                    plan_valid = 1'b0;
            end else begin
                chk("mem_rd_idle", 32'(mif.mem_rd), 32'(0));
                chk("mem_wr_idle", 32'(mif.mem_wr), 32'(0));
                comp = 1'b1;
            end
            if (comp) begin
                exp_alu   = q[0].alu;
                exp_wreg  = q[0].wreg;
                exp_rw    = q[0].rw;
                exp_halt  = q[0].halt;
                exp_m2r   = q[0].rd;
                exp_rdata = (memop && q[0].rd && !tmo) ? pdata : 16'h0;
                exp_err   = q[0].err || ill || tmo || (memop && !tmo && perr);
            end
        end else begin
            chk("mem_rd_empty", 32'(mif.mem_rd), 32'(0));
            chk("mem_wr_empty", 32'(mif.mem_wr), 32'(0));
        end
        exp_valid    = comp;
        ex_valid     = v;
        ex_alu_out   = ins.alu;
        ex_wdata     = ins.wdata;
        ex_mem_read  = ins.rd;
        ex_mem_write = ins.wr;
        ex_reg_write = ins.rw;
        ex_wreg      = ins.wreg;
        ex_halt      = ins.halt;
        ex_err       = ins.err;
        #1;
        chk("mem_ready", 32'(mem_ready), 32'((q.size() == 0) || comp));
        acc = mem_ready && v;
        if (acc)
            q.push_back(ins);
    endtask

    task automatic send(input instr_t ins);
        bit acc;
        int n;
        n = 0;
        do begin
            step(1'b1, ins, acc);
            n++;
        end while (!acc && n < 40);
        chk("send_accept", 32'(acc), 32'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wb_valid"}, 32'(wb_valid), 32'(0));
        chk({tag, "_wb_alu_out"}, 32'(wb_alu_out), 32'(0));
        chk({tag, "_wb_rdata"}, 32'(wb_rdata), 32'(0));
        chk({tag, "_wb_mem_to_reg"}, 32'(wb_mem_to_reg), 32'(0));
        chk({tag, "_wb_reg_write"}, 32'(wb_reg_write), 32'(0));
        chk({tag, "_wb_wreg"}, 32'(wb_wreg), 32'(0));
        chk({tag, "_wb_halt"}, 32'(wb_halt), 32'(0));
        chk({tag, "_wb_err"}, 32'(wb_err), 32'(0));
        chk({tag, "_mem_rd"}, 32'(mif.mem_rd), 32'(0));
        chk({tag, "_mem_wr"}, 32'(mif.mem_wr), 32'(0));
        chk({tag, "_mem_addr"}, 32'(mif.mem_addr), 32'(0));
        chk({tag, "_mem_data_out"}, 32'(mif.mem_data_out), 32'(0));
        chk({tag, "_mem_ready"}, 32'(mem_ready), 32'(1));
    endtask

    initial begin
        instr_t ins;
        instr_t idle;
        bit     acc;
        int     n;
        idle = '0;
        rst_n = 1'b1;
        ex_valid = 1'b0; ex_alu_out = '0; ex_wdata = '0; ex_mem_read = 1'b0;
        ex_mem_write = 1'b0; ex_reg_write = 1'b0; ex_wreg = '0; ex_halt = 1'b0; ex_err = 1'b0;
        mif.mem_stall = 1'b0; mif.mem_done = 1'b0; mif.mem_data_in = '0; mif.mem_err = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases from the block's test plan.
        send(mk(16'h0011, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd3));
        send(mk(16'h0022, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd4));
        ins = mk(16'h0040, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd1);
        ins.f_en = 1'b1; ins.f_s = 0; ins.f_l = 0; ins.f_data = 16'hBEEF;
        send(ins);
        ins = mk(16'h0080, 16'h1234, 1'b0, 1'b1, 1'b0, 3'd0);
        ins.f_en = 1'b1; ins.f_s = 2; ins.f_l = 3; ins.f_data = 16'h0000;
        send(ins);
        send(mk(16'h0041, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd2));
        send(mk(16'h0010, 16'h5555, 1'b1, 1'b1, 1'b1, 3'd6));
        ins = mk(16'h0020, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd7);
        ins.f_en = 1'b1; ins.f_s = 0; ins.f_l = 20; ins.f_data = 16'hDEAD;
        send(ins);
        send(mk(16'h0033, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd5));
        ins = mk(16'h0044, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd1);
        ins.f_en = 1'b1; ins.f_s = 3; ins.f_l = TMO - 4; ins.f_data = 16'h5A5A;
        send(ins);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            ins = rand_instr();
            step(($urandom_range(0, 3) != 0), ins, acc);
        end

        n = 0;
        while (q.size() > 0 && n < 60) begin
            step(1'b0, idle, acc);
            n++;
        end
        chk("drain_empty", 32'(q.size()), 32'(0));

        // Reset while an access sits in WAIT.
        ins = mk(16'h0100, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd5);
        ins.f_en = 1'b1; ins.f_s = 0; ins.f_l = 9; ins.f_data = 16'hAAAA;
        send(ins);
        step(1'b0, idle, acc);
        step(1'b0, idle, acc);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midwait");
        q.delete();
        plan_valid = 1'b0;
        exp_valid  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) step(1'b0, idle, acc);
        send(mk(16'h0077, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd2));
        repeat (2) step(1'b0, idle, acc);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
